filtro_botao_pulso: RTL and testbench
=====================================

// Module: filtro_botao_pulso
// PURPOSE
//  Debounces one active-high push-button level and emits a clean level plus a one-cycle press strobe.
//  Sits upstream of the up/down counter: button_output drives the counter's clock input
//  (one rising edge per accepted press); button_pulse serves synchronous consumers.
//  A 2-FF synchronizer feeds a 4-state debounce FSM with a shared stability counter.
// PARAMETERS
//  DEBOUNCE_CYCLES      1_000_000   stable cycles needed to accept press/release (20 ms @ 50 MHz), >=2
//  REPEAT_DELAY_CYCLES  25_000_000  hold time before first auto-repeat pulse (AUTO_REPEAT_EN only)
//  REPEAT_RATE_CYCLES   10_000_000  period between later auto-repeat pulses (AUTO_REPEAT_EN only)
// PORTS
//  clock_fpga     in   1  system clock (50 MHz board clock)
//  reset          in   1  asynchronous, active-low reset
//  button_input   in   1  raw button level, active-high (already inverted from KEY), asynchronous
//  button_output  out  1  debounced level; 1 while press accepted
//  button_pulse   out  1  one-cycle strobe per accepted press (and per repeat when enabled)
// BEHAVIOUR
//  - Reset (reset=0, async): sync FFs=0, state=IDLE, counters=0, button_output=0, button_pulse=0.
//  - button_input passes 2 FFs -> sync_in; FSM sees only sync_in.
//  - Stability counter width = $clog2(DEBOUNCE_CYCLES); cleared on every state entry.
//  - States/transitions (evaluated each clock_fpga rising edge):
//    IDLE:            sync_in=1 -> CONFIRM_PRESS.
//    CONFIRM_PRESS:   sync_in=0 -> IDLE (bounce rejected, no output change);
//                     count==DEBOUNCE_CYCLES-1 with sync_in=1 -> PRESSED, button_output<=1, button_pulse<=1 (1 cycle).
//    PRESSED:         sync_in=0 -> CONFIRM_RELEASE.
//    CONFIRM_RELEASE: sync_in=1 -> PRESSED (no new pulse);
//                     count==DEBOUNCE_CYCLES-1 with sync_in=0 -> IDLE, button_output<=0.
//  - Latency: clean input edge -> button_output change = 2 + DEBOUNCE_CYCLES cycles.
//    button_pulse asserts same cycle button_output rises.
//  - Any input shorter than DEBOUNCE_CYCLES produces no output change.
//  - button_output only changes in CONFIRM_* completions, so at most one rising edge per accepted press.
//  - Counters saturate, never wrap; unused states decode to IDLE.
//  - Reset mid-confirm or mid-press: outputs drop to 0 immediately; no pulse on reset release
//    even if button held (press must re-confirm from IDLE).
// CONFIGURATION
//  AUTO_REPEAT_EN defined:
//    - Hold timer (width $clog2(max(REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES))) cleared on
//      CONFIRM_PRESS->PRESSED.
//    - Counts in PRESSED; frozen in CONFIRM_RELEASE; cleared in IDLE.
//    - First extra button_pulse at REPEAT_DELAY_CYCLES of hold, then every REPEAT_RATE_CYCLES.
//    - button_output stays 1 throughout (no extra edges).
//  AUTO_REPEAT_EN undefined:
//    - No hold timer is built; exactly one button_pulse per accepted press.
//    - REPEAT_* parameters ignored.
// TESTING (bench: DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=10, REPEAT_RATE_CYCLES=5)
//  1. Reset low 3 cycles, input=1 -> outputs 0; release reset, input held 1 ->
//     button_output=1 exactly 6 cycles later, single 1-cycle pulse.
//  2. Input 1 for 3 cycles then 0 (bounce) -> button_output and button_pulse stay 0.
//  3. Clean press 20 cycles then release -> one pulse; button_output falls 6 cycles after release.
//  4. While pressed, input 0 for 2 cycles then 1 -> button_output stays 1, no second pulse.
//  5. Reset asserted mid-PRESSED -> button_output=0 asynchronously; held input re-confirms after 6 cycles.
//  6. AUTO_REPEAT_EN, hold 30 cycles past acceptance -> pulses at +0, +10, +15, +20, +25, +30;
//     without macro, only +0.

Source files
------------

// File: rtl/filtro_botao_pulso.sv
// Push-button debouncer: 2-FF synchronizer + 4-state confirm FSM; define AUTO_REPEAT_EN for hold-to-repeat pulses.
// Latency: 2 + DEBOUNCE_CYCLES clocks from a clean input edge to a button_output change.
// No backpressure: button_pulse is a single-cycle strobe that the consumer must take when it appears.
module filtro_botao_pulso #(
   parameter int DEBOUNCE_CYCLES     = 1_000_000,
   parameter int REPEAT_DELAY_CYCLES = 25_000_000,
   parameter int REPEAT_RATE_CYCLES  = 10_000_000
) (
   input  logic clock_fpga,
   input  logic reset,
   input  logic button_input,
   output logic button_output,
   output logic button_pulse
);
   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, CONFIRM_PRESS, PRESSED, CONFIRM_RELEASE} state_t;

   logic [1:0]       sync_q, sync_d;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             out_q, out_d;
   logic             pulse_q, pulse_d;
   logic             sync_in;
   logic             accept;
   logic             rep_fire;

   if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY_CYCLES < 1 || REPEAT_RATE_CYCLES < 1) begin : g_param_check
      $error("filtro_botao_pulso: DEBOUNCE_CYCLES must be >= 2 and repeat periods >= 1");
   end

   always_comb begin
      sync_d = {sync_q[0], button_input};
   end
   assign sync_in = sync_q[1];

   // The stability counter restarts on every state entry; >= keeps it from ever wrapping.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      accept  = 1'b0;
      case (state_q)
         IDLE: begin
            if (sync_in) begin
               state_d = CONFIRM_PRESS;
               cnt_d   = '0;
            end
         end
         CONFIRM_PRESS: begin
            if (!sync_in) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q >= CNT_LAST) begin
               state_d = PRESSED;
               cnt_d   = '0;
               out_d   = 1'b1;
               accept  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         PRESSED: begin
            if (!sync_in) begin
               state_d = CONFIRM_RELEASE;
               cnt_d   = '0;
            end
         end
         CONFIRM_RELEASE: begin
            if (sync_in) begin
               state_d = PRESSED;
               cnt_d   = '0;
            end else if (cnt_q >= CNT_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
               out_d   = 1'b0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            out_d   = 1'b0;
         end
      endcase
   end

`ifdef AUTO_REPEAT_EN
   localparam int HOLD_MAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                             REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
   localparam int                HOLD_W     = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
   localparam logic [HOLD_W-1:0] DELAY_LAST = HOLD_W'(REPEAT_DELAY_CYCLES - 1);
   localparam logic [HOLD_W-1:0] RATE_LAST  = HOLD_W'(REPEAT_RATE_CYCLES - 1);

   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              rep_q, rep_d;

   // rep_q selects the initial delay versus the steady repeat period; the timer freezes during release confirm.
   always_comb begin
      hold_d   = hold_q;
      rep_d    = rep_q;
      rep_fire = 1'b0;
      if (accept || state_q == IDLE) begin
         hold_d = '0;
         rep_d  = 1'b0;
      end else if (state_q == PRESSED) begin
         if (hold_q >= (rep_q ? RATE_LAST : DELAY_LAST)) begin
            rep_fire = 1'b1;
            hold_d   = '0;
            rep_d    = 1'b1;
         end else begin
            hold_d = hold_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clock_fpga or negedge reset) begin
      if (!reset) begin
         hold_q <= '0;
         rep_q  <= 1'b0;
      end else begin
         hold_q <= hold_d;
         rep_q  <= rep_d;
      end
   end
`else
   assign rep_fire = 1'b0;
`endif

   always_comb begin
      pulse_d = accept | rep_fire;
   end

   always_ff @(posedge clock_fpga or negedge reset) begin
      if (!reset) begin
         sync_q  <= '0;
         state_q <= IDLE;
         cnt_q   <= '0;
         out_q   <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         pulse_q <= pulse_d;
      end
   end

   assign button_output = out_q;
   assign button_pulse  = pulse_q;

endmodule

// File: tb/tb_filtro_botao_pulso.sv
// Bench for filtro_botao_pulso: directed scenarios plus random button activity against a run-length reference model.
// Build with AUTO_REPEAT_EN defined or not; expectations follow the same macro.
module tb_filtro_botao_pulso;
   localparam int D  = 4;
   localparam int RD = 10;
   localparam int RR = 5;
   localparam int LAT = 2 + D;

   logic clock_fpga   = 1'b0;
   logic reset        = 1'b0;
   logic button_input = 1'b0;
   logic button_output;
   logic button_pulse;

   int checks = 0;
   int errors = 0;
   int pulses = 0;

   // reference model state
   logic m_s1, m_s2, m_out, m_pulse;
   int   m_run, m_held;

   filtro_botao_pulso #(
      .DEBOUNCE_CYCLES    (D),
      .REPEAT_DELAY_CYCLES(RD),
      .REPEAT_RATE_CYCLES (RR)
   ) dut (
      .clock_fpga   (clock_fpga),
      .reset        (reset),
      .button_input (button_input),
      .button_output(button_output),
      .button_pulse (button_pulse)
   );

   always #5 clock_fpga = ~clock_fpga;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_s1 = 1'b0; m_s2 = 1'b0; m_out = 1'b0; m_pulse = 1'b0;
      m_run = 0; m_held = 0;
   endfunction

   // Level flips once the synchronized input has disagreed with it for D+1 consecutive samples.
   function automatic void model_edge(input logic v);
      logic smp;
      bit   was_pressed;
      smp         = m_s2;
      was_pressed = m_out && (m_run == 0);
      m_s2        = m_s1;
      m_s1        = v;
      m_pulse     = 1'b0;
      if (smp != m_out) m_run++;
      else m_run = 0;
      if (m_run == D + 1) begin
         m_out = !m_out;
         m_run = 0;
         if (m_out) begin
            m_pulse = 1'b1;
            m_held  = 0;
         end
      end
`ifdef AUTO_REPEAT_EN
      if (was_pressed) begin
         m_held++;
         if (m_held == RD || (m_held > RD && (m_held - RD) % RR == 0)) m_pulse = 1'b1;
      end
`endif
   endfunction

   task automatic step(input logic v);
      @(negedge clock_fpga);
      button_input = v;
      @(posedge clock_fpga);
      if (!reset) model_reset();
      else model_edge(v);
      #1;
      chk("out", {31'd0, button_output}, {31'd0, m_out});
      chk("pulse", {31'd0, button_pulse}, {31'd0, m_pulse});
      if (button_pulse) pulses++;
   endtask

   task automatic latency(input logic v, input string tag);
      int n;
      n = 0;
      step(v);
      while (button_output !== v && n < 20) begin
         step(v);
         n++;
      end
      chk(tag, n, LAT);
   endtask

   task automatic rst_pulse(input int n);
      #2 reset = 1'b0;
      model_reset();
      #1;
      chk("rst_async_out", {31'd0, button_output}, 32'd0);
      chk("rst_async_pulse", {31'd0, button_pulse}, 32'd0);
      repeat (n) step(button_input);
      #2 reset = 1'b1;
   endtask

   initial begin
      int          p0;
      logic [31:0] mask;
      logic        v;
      int          len;

      // 1: held input during reset, then acceptance after release
      button_input = 1'b1;
      model_reset();
      #1;
      chk("reset_out", {31'd0, button_output}, 32'd0);
      chk("reset_pulse", {31'd0, button_pulse}, 32'd0);
      repeat (3) step(1'b1);
      p0 = pulses;
      #2 reset = 1'b1;
      latency(1'b1, "lat_after_reset");
      chk("pulse_cnt_first", pulses - p0, 1);
      latency(1'b0, "lat_release1");
      repeat (3) step(1'b0);

      // 2: short bounce is rejected
      p0 = pulses;
      repeat (3) step(1'b1);
      repeat (8) step(1'b0);
      chk("bounce_pulse", pulses - p0, 0);
      chk("bounce_out", {31'd0, button_output}, 32'd0);

      // 3: clean 20-cycle press
      p0 = pulses;
      repeat (20) step(1'b1);
      latency(1'b0, "lat_release20");
`ifdef AUTO_REPEAT_EN
      chk("pulse_cnt_hold20", pulses - p0, 3);
`else
      chk("pulse_cnt_hold20", pulses - p0, 1);
`endif
      repeat (3) step(1'b0);

      // 4: release glitch while pressed
      latency(1'b1, "lat_press2");
      repeat (3) step(1'b1);
      p0 = pulses;
      repeat (2) step(1'b0);
      repeat (4) step(1'b1);
      chk("glitch_pulse", pulses - p0, 0);
      chk("glitch_out", {31'd0, button_output}, 32'd1);
      latency(1'b0, "lat_release2");
      repeat (3) step(1'b0);

      // 5: reset in the middle of a press
      latency(1'b1, "lat_press3");
      repeat (2) step(1'b1);
      rst_pulse(2);
      p0 = pulses;
      latency(1'b1, "lat_reconfirm");
      chk("reconfirm_pulse", pulses - p0, 1);
      latency(1'b0, "lat_release3");
      repeat (3) step(1'b0);

      // 6: long hold, pulse positions relative to acceptance
      latency(1'b1, "lat_press4");
      mask = {31'd0, button_pulse};
      for (int i = 1; i <= 30; i++) begin
         step(1'b1);
         if (button_pulse) mask = mask | (32'd1 << i);
      end
`ifdef AUTO_REPEAT_EN
      chk("repeat_mask", mask, 32'h4210_8401);
`else
      chk("repeat_mask", mask, 32'h0000_0001);
`endif
      latency(1'b0, "lat_release4");
      repeat (3) step(1'b0);

      // random activity with occasional resets
      for (int s = 0; s < 300; s++) begin
         if ($urandom_range(0, 39) == 0) rst_pulse(int'($urandom_range(1, 3)));
         v   = 1'($urandom_range(0, 1));
         len = ($urandom_range(0, 5) == 0) ? int'($urandom_range(10, 40)) : int'($urandom_range(1, 7));
         for (int k = 0; k < len; k++) step(v);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
